rd_preamble_ctrl: RTL and testbench
===================================

Name: rd_preamble_ctrl

Overview:
Read-path sequencer for the Data Manager read module. Buffers incoming read commands and times each one out to the read-latency point. It then enables the DQS preamble pattern detector, waits for its detect pulse, and opens the DQ capture window for the burst. It finishes by holding for the postamble and reports completion, or a timeout error if no preamble arrives.

Parameters:
CMD_DEPTH, 4, pending read-command FIFO entries (power of 2, >=2)
RL_W, 7, width of read-latency field
SEARCH_TIMEOUT, 16, max cycles in SEARCH before error
TO_W, 5, timeout counter width (must hold SEARCH_TIMEOUT)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
rd_cmd_valid_i  in  1  read command request
rd_cmd_ready_o  out  1  FIFO can accept (= not full)
rd_cmd_bl16_i  in  1  1: BL16, 0: BL8; stored with command
rl_i  in  RL_W  read latency in clocks, sampled at pop
pre_amble_sett_i  in  3  preamble setting, sampled at pop
post_amble_sett_i  in  1  postamble setting, sampled at pop
det_en_o  out  1  pattern-detector enable
det_pre_amble_sett_o  out  3  latched preamble setting to detector
det_post_amble_sett_o  out  1  latched postamble setting to detector
det_pattern_detected_i  in  1  detector one-cycle detect pulse
capture_en_o  out  1  DQ capture window
busy_o  out  1  FSM not IDLE
rd_done_o  out  1  one-cycle pulse, read completed
rd_err_o  out  1  one-cycle pulse, preamble timeout

Behaviour:
- Reset (async, reset_i=1): FSM=IDLE, FIFO empty, all counters 0. All outputs 0 except rd_cmd_ready_o=1. Latched settings are 0. Any reset mid-operation aborts the in-flight read with no done/err pulse.
- FIFO: push when rd_cmd_valid_i & rd_cmd_ready_o. Stores bl16. Pop occurs only in IDLE when non-empty. A simultaneous push and pop is legal. When full, ready=0 even if a pop happens in the same cycle (no bypass).
- Pop cycle latches rl_i, pre_amble_sett_i and post_amble_sett_i. Later changes do not affect the in-flight read.
- pre_len from setting: 000→2, 001→4, 010→4, 011→6, 100→8, other→2.
- post_len: sett 0→1, 1→2.
- burst cycles: BL16→8, BL8→4.
- FSM states:
  - IDLE → WAIT_RL on pop. Load cnt = rl − pre_len, saturating at 0.
  - WAIT_RL: decrement each cycle. When cnt==0 → SEARCH and load the timeout counter.
  - SEARCH: det_en_o=1. A detect pulse moves to CAPTURE and loads burst cycles. If SEARCH_TIMEOUT cycles pass with no pulse → IDLE with rd_err_o=1 for one cycle.
  - CAPTURE: capture_en_o=1 for exactly burst-cycle clocks, then → POST with post_len loaded.
  - POST: hold post_len cycles, then → IDLE with rd_done_o=1 for one cycle.
- Detect-pulse edge cases:
  - A pulse on the same cycle the timeout expires counts as a detection; no error.
  - Pulses outside SEARCH are ignored.
- det_pre/post outputs are driven from the latched values at all times.
- busy_o=1 in every state except IDLE.
- Back-to-back reads: the next pop can occur in the IDLE cycle immediately after done/err. Minimum gap is 1 cycle.

Decomposition:
- Shared package rd_ctrl_pkg holds:
  - FSM state encodings (IDLE, WAIT_RL, SEARCH, CAPTURE, POST)
  - preamble-setting codes and the pre_len lookup function
  - BL8/BL16 cycle constants
  - post_len function
- Sub-module rd_cmd_fifo: synchronous FIFO of CMD_DEPTH×1 bit with full/empty flags, same clock/reset. The FSM stays in the top level.

Test Plan:
- Single read, rl=10, sett=001, BL16, post=0, detect 3 cycles into SEARCH:
  - det_en_o rises 7 cycles after pop
  - capture_en_o high 8 cycles
  - rd_done_o 1 cycle after POST, total 1+6+3+8+1 cycles
- No detect pulse, sett=100, rl=12:
  - det_en_o high exactly 16 cycles
  - rd_err_o pulses once
  - capture_en_o never asserts
  - FSM returns to IDLE
- Push 5 commands back-to-back while the first is in SEARCH:
  - ready drops after the 4th stored entry
  - 5th is held until a pop
  - all 5 complete in order with BL mix preserved
- rl=1 with sett=100 (rl<pre_len): saturates to 0, so SEARCH is entered the cycle after pop.
- Assert reset_i mid-CAPTURE:
  - capture_en_o and det_en_o drop immediately (async)
  - FIFO empty, no done/err pulse
  - ready=1 after release
- Change pre_amble_sett_i from 001 to 011 during WAIT_RL: det_pre_amble_sett_o stays 001 until the next pop.

Source files
------------

// File: rtl/rd_preamble_ctrl_pkg.sv
// Shared definitions for the read-path preamble sequencer: FSM encodings,
// preamble setting codes, burst/postamble lengths and their lookups.
package rd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_RL = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_POST    = 3'd4
    } state_t;

    // Preamble setting codes as presented on pre_amble_sett_i.
    localparam logic [2:0] PRE_SETT_2  = 3'b000;
    localparam logic [2:0] PRE_SETT_4A = 3'b001;
    localparam logic [2:0] PRE_SETT_4B = 3'b010;
    localparam logic [2:0] PRE_SETT_6  = 3'b011;
    localparam logic [2:0] PRE_SETT_8  = 3'b100;

    // DQ clocks occupied by one burst.
    localparam logic [3:0] BL8_CYCLES  = 4'd4;
    localparam logic [3:0] BL16_CYCLES = 4'd8;

    // Preamble length in clocks; unknown codes fall back to the shortest.
    function automatic logic [3:0] pre_len(input logic [2:0] sett);
        logic [3:0] len;
        case (sett)
            PRE_SETT_2:  len = 4'd2;
            PRE_SETT_4A: len = 4'd4;
            PRE_SETT_4B: len = 4'd4;
            PRE_SETT_6:  len = 4'd6;
            PRE_SETT_8:  len = 4'd8;
            default:     len = 4'd2;
        endcase
        return len;
    endfunction

    // Postamble hold length in clocks.
    function automatic logic [1:0] post_len(input logic sett);
        return sett ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/rd_preamble_ctrl_if.sv
// Command and pattern-detector signals of the read sequencer.
// Handshake: a command is accepted on a rising clk_i edge where
// rd_cmd_valid_i and rd_cmd_ready_o are both 1; valid may be held while
// ready is 0 and the command fields must stay stable until accepted.
interface rd_preamble_ctrl_if #(
    parameter int RL_W = 7
) ();
    import rd_ctrl_pkg::*;

    logic            rd_cmd_valid_i;
    logic            rd_cmd_ready_o;
    logic            rd_cmd_bl16_i;
    logic [RL_W-1:0] rl_i;
    logic [2:0]      pre_amble_sett_i;
    logic            post_amble_sett_i;
    logic            det_en_o;
    logic [2:0]      det_pre_amble_sett_o;
    logic            det_post_amble_sett_o;
    logic            det_pattern_detected_i;
    logic            capture_en_o;
    logic            busy_o;
    logic            rd_done_o;
    logic            rd_err_o;
    state_t          dbg_state;

    modport slave (
        input  rd_cmd_valid_i, rd_cmd_bl16_i, rl_i, pre_amble_sett_i,
               post_amble_sett_i, det_pattern_detected_i,
        output rd_cmd_ready_o, det_en_o, det_pre_amble_sett_o,
               det_post_amble_sett_o, capture_en_o, busy_o, rd_done_o,
               rd_err_o, dbg_state
    );

    modport master (
        output rd_cmd_valid_i, rd_cmd_bl16_i, rl_i, pre_amble_sett_i,
               post_amble_sett_i, det_pattern_detected_i,
        input  rd_cmd_ready_o, det_en_o, det_pre_amble_sett_o,
               det_post_amble_sett_o, capture_en_o, busy_o, rd_done_o,
               rd_err_o, dbg_state
    );

endinterface

// File: rtl/rd_preamble_ctrl_cmd_fifo.sv
// Pending read-command FIFO: one bit (BL16 flag) per entry, pointer-based
// with an extra wrap bit to tell full from empty. Head is read combinationally.
module rd_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic push,
    input  logic wr_data,
    input  logic pop,
    output logic rd_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage and pointer update; overflow/underflow requests are dropped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rd_preamble_ctrl.sv
// Read-path sequencer: pops buffered read commands, waits out the read
// latency minus the preamble, searches for the DQS preamble, opens the
// capture window for the burst, holds the postamble and reports done/error.
module rd_preamble_ctrl
    import rd_ctrl_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int RL_W           = 7,
    parameter int SEARCH_TIMEOUT = 16,
    parameter int TO_W           = 5
) (
    input logic              clk_i,
    input logic              reset_i,
    rd_preamble_ctrl_if.slave bus
);
    state_t          state;
    logic [RL_W-1:0] cnt;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      pre_sett_q;
    logic            post_sett_q;
    logic            bl16_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_bl16;
    logic            push;
    logic            pop;
    logic [RL_W-1:0] pre_ext;
    logic [RL_W-1:0] wait_load;

    assign push = bus.rd_cmd_valid_i && !fifo_full;
    assign pop  = (state == ST_IDLE) && !fifo_empty;

    // Clocks to wait before the preamble search; saturates when rl < preamble.
    assign pre_ext   = RL_W'(pre_len(bus.pre_amble_sett_i));
    assign wait_load = (bus.rl_i > pre_ext) ? (bus.rl_i - pre_ext) : '0;

    rd_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .wr_data (bus.rd_cmd_bl16_i),
        .pop     (pop),
        .rd_data (fifo_bl16),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sequencer FSM with registered outputs; counters count the remaining
    // clocks of the current phase and the phase ends when they reach 1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            to_cnt         <= '0;
            pre_sett_q     <= '0;
            post_sett_q    <= 1'b0;
            bl16_q         <= 1'b0;
            bus.det_en_o     <= 1'b0;
            bus.capture_en_o <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.rd_done_o    <= 1'b0;
            bus.rd_err_o     <= 1'b0;
        end else begin
            bus.rd_done_o <= 1'b0;
            bus.rd_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        pre_sett_q  <= bus.pre_amble_sett_i;
                        post_sett_q <= bus.post_amble_sett_i;
                        bl16_q      <= fifo_bl16;
                        bus.busy_o  <= 1'b1;
                        if (wait_load == '0) begin
                            state        <= ST_SEARCH;
                            to_cnt       <= TO_W'(SEARCH_TIMEOUT);
                            bus.det_en_o <= 1'b1;
                        end else begin
                            state <= ST_WAIT_RL;
                            cnt   <= wait_load;
                        end
                    end
                end
                ST_WAIT_RL: begin
                    if (cnt == RL_W'(1)) begin
                        state        <= ST_SEARCH;
                        to_cnt       <= TO_W'(SEARCH_TIMEOUT);
                        bus.det_en_o <= 1'b1;
                    end else begin
                        cnt <= cnt - RL_W'(1);
                    end
                end
                ST_SEARCH: begin
                    // A detect on the final timeout cycle still wins.
                    if (bus.det_pattern_detected_i) begin
                        state            <= ST_CAPTURE;
                        cnt              <= RL_W'(bl16_q ? BL16_CYCLES : BL8_CYCLES);
                        bus.det_en_o     <= 1'b0;
                        bus.capture_en_o <= 1'b1;
                    end else if (to_cnt == TO_W'(1)) begin
                        state        <= ST_IDLE;
                        bus.det_en_o <= 1'b0;
                        bus.busy_o   <= 1'b0;
                        bus.rd_err_o <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (cnt == RL_W'(1)) begin
                        state            <= ST_POST;
                        cnt              <= RL_W'(post_len(post_sett_q));
                        bus.capture_en_o <= 1'b0;
                    end else begin
                        cnt <= cnt - RL_W'(1);
                    end
                end
                ST_POST: begin
                    if (cnt == RL_W'(1)) begin
                        state         <= ST_IDLE;
                        bus.busy_o    <= 1'b0;
                        bus.rd_done_o <= 1'b1;
                    end else begin
                        cnt <= cnt - RL_W'(1);
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    bus.det_en_o     <= 1'b0;
                    bus.capture_en_o <= 1'b0;
                    bus.busy_o       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_cmd_ready_o        = !fifo_full;
    assign bus.det_pre_amble_sett_o  = pre_sett_q;
    assign bus.det_post_amble_sett_o = post_sett_q;
    assign bus.dbg_state             = state;

endmodule

// File: tb/tb_rd_preamble_ctrl.sv
// Directed bench for rd_preamble_ctrl: inputs driven and outputs sampled on
// the falling clock edge, expected values computed by hand from the timing.
module tb_rd_preamble_ctrl;
    import rd_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   done_cnt;
    int   err_cnt;
    int   cap_cnt;
    logic [3:0] exp_q[$];
    logic bl_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rd_preamble_ctrl_if #(.RL_W(7)) bus ();

    rd_preamble_ctrl #(
        .CMD_DEPTH(4), .RL_W(7), .SEARCH_TIMEOUT(16), .TO_W(5)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle and pulse counters, sampled on the active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rd_done_o)    done_cnt <= done_cnt + 1;
        if (bus.rd_err_o)     err_cnt  <= err_cnt + 1;
        if (bus.capture_en_o) cap_cnt  <= cap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one-cycle command push; fields stay held so the pop samples them
    task automatic push_cmd(input logic bl16, input logic [6:0] rl,
                            input logic [2:0] pre, input logic post);
        bus.rd_cmd_valid_i    = 1'b1;
        bus.rd_cmd_bl16_i     = bl16;
        bus.rl_i              = rl;
        bus.pre_amble_sett_i  = pre;
        bus.post_amble_sett_i = post;
        step(1);
        bus.rd_cmd_valid_i    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy_o && n < 60) begin step(1); n++; end
        chk(tag, bus.busy_o, 0);
    endtask

    initial begin
        int n;
        int t0;
        int e0;
        int d0;
        int c0;
        checks = 0; failures = 0; cyc = 0;
        done_cnt = 0; err_cnt = 0; cap_cnt = 0;
        bus.rd_cmd_valid_i = 0; bus.rd_cmd_bl16_i = 0; bus.rl_i = 0;
        bus.pre_amble_sett_i = 0; bus.post_amble_sett_i = 0;
        bus.det_pattern_detected_i = 0;
        rst = 1'b1;
        step(2);
        chk("rst_ready", bus.rd_cmd_ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_det_en", bus.det_en_o, 0);
        chk("rst_capture", bus.capture_en_o, 0);
        chk("rst_done", bus.rd_done_o, 0);
        chk("rst_err", bus.rd_err_o, 0);
        chk("rst_det_pre", bus.det_pre_amble_sett_o, 0);
        chk("rst_det_post", bus.det_post_amble_sett_o, 0);
        rst = 1'b0;
        step(1);
        chk("rst_state", bus.dbg_state, ST_IDLE);

        // single read: rl=10, pre 001 (4), BL16, post 0, detect on 3rd SEARCH cycle
        push_cmd(1'b1, 7'd10, 3'b001, 1'b0);
        t0 = cyc;
        n = 0;
        while (!bus.det_en_o && n < 40) begin step(1); n++; end
        chk("t1_det_en_rise", n, 7);
        chk("t1_det_pre", bus.det_pre_amble_sett_o, 1);
        step(2);
        bus.det_pattern_detected_i = 1'b1;
        step(1);
        bus.det_pattern_detected_i = 1'b0;
        chk("t1_state_capture", bus.dbg_state, ST_CAPTURE);
        chk("t1_det_en_off", bus.det_en_o, 0);
        n = 0;
        while (bus.capture_en_o && n < 40) begin step(1); n++; end
        chk("t1_capture_len", n, 8);
        chk("t1_state_post", bus.dbg_state, ST_POST);
        chk("t1_done_early", bus.rd_done_o, 0);
        step(1);
        chk("t1_done", bus.rd_done_o, 1);
        chk("t1_total_cycles", cyc - t0, 19);
        chk("t1_busy_after", bus.busy_o, 0);
        step(1);
        chk("t1_done_one_cycle", bus.rd_done_o, 0);

        // timeout: rl=12, pre 100 (8), no detect pulse
        e0 = err_cnt; c0 = cap_cnt;
        push_cmd(1'b0, 7'd12, 3'b100, 1'b0);
        n = 0;
        while (!bus.det_en_o && n < 40) begin step(1); n++; end
        chk("t2_wait_len", n, 5);
        n = 0;
        while (bus.det_en_o && n < 40) begin step(1); n++; end
        chk("t2_det_en_len", n, 16);
        chk("t2_err", bus.rd_err_o, 1);
        chk("t2_state_idle", bus.dbg_state, ST_IDLE);
        step(1);
        chk("t2_err_one_cycle", bus.rd_err_o, 0);
        chk("t2_err_count", err_cnt - e0, 1);
        chk("t2_no_capture", cap_cnt - c0, 0);

        // rl=1 below preamble 8: SEARCH right after the pop
        push_cmd(1'b1, 7'd1, 3'b100, 1'b0);
        step(1);
        chk("t3_det_en", bus.det_en_o, 1);
        chk("t3_state_search", bus.dbg_state, ST_SEARCH);
        wait_idle("t3_idle");
        step(1);

        // setting change during WAIT_RL does not reach the detector
        push_cmd(1'b0, 7'd10, 3'b001, 1'b1);
        step(1);
        chk("t4_state_wait", bus.dbg_state, ST_WAIT_RL);
        bus.pre_amble_sett_i = 3'b011;
        step(3);
        chk("t4_det_pre_hold", bus.det_pre_amble_sett_o, 1);
        chk("t4_det_post", bus.det_post_amble_sett_o, 1);
        n = 0;
        while (!bus.det_en_o && n < 40) begin step(1); n++; end
        chk("t4_det_pre_search", bus.det_pre_amble_sett_o, 1);
        bus.det_pattern_detected_i = 1'b1;
        step(1);
        bus.det_pattern_detected_i = 1'b0;
        n = 0;
        while (bus.capture_en_o && n < 40) begin step(1); n++; end
        chk("t4_capture_bl8", n, 4);
        n = 0;
        while (bus.dbg_state == ST_POST && n < 10) begin step(1); n++; end
        chk("t4_post_len", n, 2);
        chk("t4_done", bus.rd_done_o, 1);
        chk("t4_det_pre_idle", bus.det_pre_amble_sett_o, 1);
        push_cmd(1'b0, 7'd1, 3'b011, 1'b0);
        step(1);
        chk("t4_det_pre_new", bus.det_pre_amble_sett_o, 3);
        chk("t4_state_search", bus.dbg_state, ST_SEARCH);
        wait_idle("t4_idle");
        step(1);

        // FIFO fill: 5 pushes while a read sits in SEARCH
        push_cmd(1'b1, 7'd1, 3'b000, 1'b0);
        step(1);
        chk("t5_state_search", bus.dbg_state, ST_SEARCH);
        e0 = err_cnt; d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.rd_cmd_valid_i = 1'b1;
            bus.rd_cmd_bl16_i  = bl_pat[i];
            chk($sformatf("t5_ready_%0d", i), bus.rd_cmd_ready_o, 1);
            step(1);
        end
        bus.rd_cmd_bl16_i = bl_pat[4];
        chk("t5_full_ready", bus.rd_cmd_ready_o, 0);
        n = 0;
        while (!bus.rd_cmd_ready_o && n < 40) begin step(1); n++; end
        chk("t5_ready_after_pop", bus.rd_cmd_ready_o, 1);
        step(1);
        bus.rd_cmd_valid_i = 1'b0;
        chk("t5_first_timeout", err_cnt - e0, 1);
        for (int i = 0; i < 5; i++) exp_q.push_back(bl_pat[i] ? 4'd8 : 4'd4);
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!bus.det_en_o && n < 40) begin step(1); n++; end
            chk($sformatf("t5_search_%0d", k), bus.det_en_o, 1);
            bus.det_pattern_detected_i = 1'b1;
            step(1);
            bus.det_pattern_detected_i = 1'b0;
            n = 0;
            while (bus.capture_en_o && n < 20) begin step(1); n++; end
            chk($sformatf("t5_burst_%0d", k), n, exp_q.pop_front());
            n = 0;
            while (!bus.rd_done_o && n < 10) begin step(1); n++; end
            chk($sformatf("t5_done_%0d", k), bus.rd_done_o, 1);
        end
        step(2);
        chk("t5_done_count", done_cnt - d0, 5);
        chk("t5_err_count", err_cnt - e0, 1);
        chk("t5_idle", bus.busy_o, 0);

        // reset in CAPTURE with a command still queued
        push_cmd(1'b1, 7'd1, 3'b000, 1'b0);
        n = 0;
        while (!bus.det_en_o && n < 40) begin step(1); n++; end
        bus.rd_cmd_valid_i = 1'b1;
        bus.rd_cmd_bl16_i  = 1'b0;
        bus.det_pattern_detected_i = 1'b1;
        step(1);
        bus.rd_cmd_valid_i = 1'b0;
        bus.det_pattern_detected_i = 1'b0;
        step(2);
        chk("t6_in_capture", bus.capture_en_o, 1);
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        #1;
        chk("t6_capture_drop", bus.capture_en_o, 0);
        chk("t6_det_en_drop", bus.det_en_o, 0);
        chk("t6_busy_drop", bus.busy_o, 0);
        chk("t6_state_idle", bus.dbg_state, ST_IDLE);
        step(1);
        rst = 1'b0;
        step(5);
        chk("t6_ready", bus.rd_cmd_ready_o, 1);
        chk("t6_fifo_empty", bus.busy_o, 0);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_no_err", err_cnt - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
